peripheral_controller: RTL and testbench

- Memory-mapped peripheral block downstream of the CPU MEM stage; consumes data-path load/store requests whose address falls in its window.
- Holds the LED output register, debounced photoresistor inputs with sticky edge flags, and a 32-bit cycle timer with compare flag.
- Returns registered read data to the MEM/WB boundary alongside a hit flag, so the CPU selects peripheral data over RAM data.

---
 rtl/peripheral_controller.sv | 200 ++++++++++++++++++++
 tb/tb_peripheral_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_controller.sv
// peripheral_controller: memory-mapped LED, photoresistor and timer block.
// Optional LED PWM dimming is built when PERIPH_PWM_EN is defined.
module peripheral_controller #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] read_data,
    output logic        hit,
    input  logic [1:0]  photores,
    output logic [4:0]  led,
    output logic        timer_irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] OFF_LED    = 3'd0;
    localparam logic [2:0] OFF_PHOTO  = 3'd1;
    localparam logic [2:0] OFF_TIMER  = 3'd2;
    localparam logic [2:0] OFF_CMP    = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;
    localparam logic [2:0] OFF_DUTY   = 3'd5;

    logic        sel;
    logic [2:0]  off;
    logic        wr;
    logic        rd;
    logic        wr_led;
    logic        wr_photo;
    logic        wr_timer;
    logic        wr_cmp;
    logic        wr_status;
    logic        unused_addr;

    logic [4:0]  led_q;
    logic [4:0]  led_d;
    logic [31:0] timer_q;
    logic [31:0] timer_d;
    logic [31:0] cmp_q;
    logic [31:0] cmp_d;
    logic        match_q;
    logic        match_d;
    logic [1:0]  sync1_q;
    logic [1:0]  sync2_q;
    logic [1:0]  level_q;
    logic [1:0]  level_d;
    logic [1:0]  edge_q;
    logic [1:0]  edge_d;
    logic [31:0] read_data_q;
    logic [31:0] read_data_d;
    logic        hit_q;
    logic        hit_d;

    logic [31:0] rd_val;
    logic [31:0] duty_rd;
    logic        pwm_on;

    assign sel = (address[31:5] == BASE_ADDR[31:5]);
    assign off = address[4:2];
    assign wr  = mem_write && sel;
    assign rd  = mem_read && sel;

    assign wr_led    = wr && (off == OFF_LED);
    assign wr_photo  = wr && (off == OFF_PHOTO);
    assign wr_timer  = wr && (off == OFF_TIMER);
    assign wr_cmp    = wr && (off == OFF_CMP);
    assign wr_status = wr && (off == OFF_STATUS);

    // Byte lane bits are not decoded: only word accesses exist.
    assign unused_addr = ^address[1:0];

    // Per-bit debounce: accept a new level only after a stable run.
    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          lvl_d;

        // Count cycles the synchronized input disagrees with the level.
        always_comb begin
            cnt_d = '0;
            lvl_d = level_q[i];
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q == CNT_LAST) begin
                    lvl_d = sync2_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Debounce counter register.
        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign level_d[i] = lvl_d;
    end

`ifdef PERIPH_PWM_EN
    logic       wr_duty;
    logic [7:0] duty_q;
    logic [7:0] duty_d;
    logic [7:0] pwm_q;

    assign wr_duty = wr && (off == OFF_DUTY);
    assign duty_d  = wr_duty ? write_data[7:0] : duty_q;
    assign pwm_on  = (pwm_q < duty_q);
    assign duty_rd = {24'd0, duty_q};

    // Free-running PWM phase counter and duty register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_q  <= 8'd0;
            duty_q <= 8'd0;
        end else begin
            pwm_q  <= pwm_q + 8'd1;
            duty_q <= duty_d;
        end
    end
`else
    assign pwm_on  = 1'b1;
    assign duty_rd = 32'd0;
`endif

    // Read mux sees pre-update values so a load+store returns old data.
    always_comb begin
        rd_val = 32'd0;
        case (off)
            OFF_LED:    rd_val = {27'd0, led_q};
            OFF_PHOTO:  rd_val = {28'd0, edge_q, level_q};
            OFF_TIMER:  rd_val = timer_q;
            OFF_CMP:    rd_val = cmp_q;
            OFF_STATUS: rd_val = {31'd0, match_q};
            OFF_DUTY:   rd_val = duty_rd;
            default:    rd_val = 32'd0;
        endcase
    end

    // Next-state for CPU-visible registers, flags and read return.
    always_comb begin
        led_d = wr_led ? write_data[4:0] : led_q;
        cmp_d = wr_cmp ? write_data : cmp_q;

        timer_d = wr_timer ? write_data : timer_q + 32'd1;

        match_d = match_q & ~(wr_status & write_data[0]);
        if (timer_d == cmp_q) begin
            match_d = 1'b1;
        end

        edge_d = edge_q & ~(wr_photo ? write_data[3:2] : 2'b00);
        edge_d = edge_d | (level_d & ~level_q);

        read_data_d = rd ? rd_val : 32'd0;
        hit_d       = rd;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            led_q       <= 5'd0;
            timer_q     <= 32'd0;
            cmp_q       <= 32'd0;
            match_q     <= 1'b0;
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            level_q     <= 2'b00;
            edge_q      <= 2'b00;
            read_data_q <= 32'd0;
            hit_q       <= 1'b0;
        end else begin
            led_q       <= led_d;
            timer_q     <= timer_d;
            cmp_q       <= cmp_d;
            match_q     <= match_d;
            sync1_q     <= photores;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            edge_q      <= edge_d;
            read_data_q <= read_data_d;
            hit_q       <= hit_d;
        end
    end

    assign read_data = read_data_q;
    assign hit       = hit_q;
    assign timer_irq = match_q;
    assign led       = ~(led_q & {5{pwm_on}});

endmodule

// File: tb/tb_peripheral_controller.sv
// tb_peripheral_controller: random + directed checks against a
// behavioural model of the peripheral register file.
module tb_peripheral_controller;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          DEB  = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] read_data;
    logic        hit;
    logic [1:0]  photores;
    logic [4:0]  led;
    logic        timer_irq;

    always #5 clock = ~clock;

    peripheral_controller #(
        .BASE_ADDR(BASE),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .address(address),
        .write_data(write_data),
        .mem_write(mem_write),
        .mem_read(mem_read),
        .read_data(read_data),
        .hit(hit),
        .photores(photores),
        .led(led),
        .timer_irq(timer_irq)
    );

    int checks = 0;
    int passes = 0;

    // Reference model state.
    logic [4:0]  m_led;
    logic [31:0] m_timer;
    logic [31:0] m_cmp;
    logic        m_match;
    logic [1:0]  m_s1;
    logic [1:0]  m_s2;
    logic [1:0]  m_level;
    logic [1:0]  m_edge;
    int          m_run [2];
    logic [7:0]  m_duty;
    logic [7:0]  m_pwm;
    logic [31:0] m_rd;
    logic        m_hit;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [4:0] exp_led();
        logic [4:0] on;
        on = m_led;
`ifdef PERIPH_PWM_EN
        if (!(m_pwm < m_duty)) on = 5'd0;
`endif
        return ~on;
    endfunction

    task automatic model(input logic rst, input logic [31:0] a,
                         input logic [31:0] wd, input logic we,
                         input logic re, input logic [1:0] ph);
        logic        in_win;
        int          o;
        logic [31:0] rv;
        logic [31:0] tn;
        logic [1:0]  nl;
        if (rst) begin
            m_led = 0; m_timer = 0; m_cmp = 0; m_match = 0;
            m_s1 = 0; m_s2 = 0; m_level = 0; m_edge = 0;
            m_run[0] = 0; m_run[1] = 0;
            m_duty = 0; m_pwm = 0; m_rd = 0; m_hit = 0;
            return;
        end
        in_win = (a >= BASE) && (a < BASE + 32);
        o = int'((a - BASE) >> 2);
        rv = 0;
        if (o == 0) rv = {27'd0, m_led};
        if (o == 1) rv = {28'd0, m_edge, m_level};
        if (o == 2) rv = m_timer;
        if (o == 3) rv = m_cmp;
        if (o == 4) rv = {31'd0, m_match};
`ifdef PERIPH_PWM_EN
        if (o == 5) rv = {24'd0, m_duty};
`endif
        m_hit = re && in_win;
        m_rd  = m_hit ? rv : 0;
        tn = (we && in_win && o == 2) ? wd : m_timer + 1;
        for (int i = 0; i < 2; i++) begin
            nl[i] = m_level[i];
            if (m_s2[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    nl[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (we && in_win && o == 1) m_edge = m_edge & ~wd[3:2];
        m_edge = m_edge | (nl & ~m_level);
        if (we && in_win && o == 4 && wd[0]) m_match = 0;
        if (tn == m_cmp) m_match = 1;
        if (we && in_win && o == 0) m_led = wd[4:0];
        if (we && in_win && o == 3) m_cmp = wd;
`ifdef PERIPH_PWM_EN
        if (we && in_win && o == 5) m_duty = wd[7:0];
`endif
        m_timer = tn;
        m_level = nl;
        m_s2 = m_s1;
        m_s1 = ph;
        m_pwm = m_pwm + 8'd1;
    endtask

    task automatic step(input logic rst, input logic [31:0] a,
                        input logic [31:0] wd, input logic we,
                        input logic re);
        reset = rst;
        address = a;
        write_data = wd;
        mem_write = we;
        mem_read = re;
        @(posedge clock);
        model(rst, a, wd, we, re, photores);
        #1;
        check("read_data", read_data, m_rd);
        check("hit", {31'd0, hit}, {31'd0, m_hit});
        check("led", {27'd0, led}, {27'd0, exp_led()});
        check("irq", {31'd0, timer_irq}, {31'd0, m_match});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rnd;
        int          low;
        photores = 2'b00;
        reset = 1'b1;
        address = 0;
        write_data = 0;
        mem_write = 0;
        mem_read = 0;

        step(1, BASE, 32'h1F, 1, 1);
        step(1, BASE, 32'h1F, 1, 1);
        check("rst_led", {27'd0, led}, 32'h1F);
        check("rst_rd", read_data, 32'd0);

        step(0, BASE, 32'h15, 1, 0);
        check("led_store", {27'd0, led}, 32'h0A);
        step(0, BASE, 0, 0, 1);
        check("led_load", read_data, 32'h15);
        check("led_hit", {31'd0, hit}, 32'd1);

        step(0, 32'h2000, 0, 0, 1);
        check("out_hit", {31'd0, hit}, 32'd0);
        step(0, 32'h2000, 32'h3, 1, 0);
        step(0, BASE, 0, 0, 1);
        check("out_store", read_data, 32'h15);

        photores = 2'b01;
        idle(10);
        photores = 2'b00;
        idle(25);
        step(0, BASE + 4, 0, 0, 1);
        check("photo_glitch", read_data, 32'd0);
        photores = 2'b01;
        idle(18);
        step(0, BASE + 4, 0, 0, 1);
        check("photo_level", read_data, 32'h5);
        step(0, BASE + 4, 32'h4, 1, 0);
        step(0, BASE + 4, 0, 0, 1);
        check("photo_w1c", read_data, 32'h1);

        step(0, BASE + 12, 32'd100, 1, 0);
        step(0, BASE + 8, 32'd90, 1, 0);
        idle(9);
        check("irq_early", {31'd0, timer_irq}, 32'd0);
        idle(1);
        check("irq_match", {31'd0, timer_irq}, 32'd1);
        step(0, BASE + 16, 32'h1, 1, 0);
        check("irq_clear", {31'd0, timer_irq}, 32'd0);
        step(0, BASE + 8, 32'hFFFF_FFFF, 1, 0);
        idle(1);
        step(0, BASE + 8, 0, 0, 1);
        check("timer_wrap", read_data, 32'd0);

        step(0, BASE + 12, 32'd300, 1, 0);
        step(0, BASE + 8, 32'd290, 1, 0);
        idle(9);
        step(0, BASE + 16, 32'h1, 1, 0);
        check("set_wins", {31'd0, timer_irq}, 32'd1);

`ifdef PERIPH_PWM_EN
        step(0, BASE, 32'h1F, 1, 0);
        step(0, BASE + 20, 32'd64, 1, 0);
        low = 0;
        for (int k = 0; k < 256; k++) begin
            step(0, 0, 0, 0, 0);
            if (led == 5'b00000) low++;
        end
        check("pwm_duty64", low, 64);
        step(0, BASE + 20, 32'd0, 1, 0);
        low = 0;
        for (int k = 0; k < 256; k++) begin
            step(0, 0, 0, 0, 0);
            if (led != 5'b11111) low++;
        end
        check("pwm_duty0", low, 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 29) == 0)
                photores = photores ^ 2'($urandom_range(1, 3));
            if ($urandom_range(0, 4) != 0) begin
                a = BASE + (32'($urandom_range(0, 7)) << 2)
                    + 32'($urandom_range(0, 3));
            end else begin
                a = $urandom;
            end
            rnd = $urandom;
            wd = rnd;
            if (a[4:2] == 3'd2 && rnd[31])
                wd = m_cmp - 32'($urandom_range(1, 12));
            step($urandom_range(0, 499) == 0, a, wd,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
